// File: rtl/ci_initiator.sv
// ci_initiator: hardware initiator for Nios II style multi-cycle custom
// instructions. It accepts one command, issues it to an FX-style slave,
// waits for done (with a timeout and a two-cycle slave-reset recovery path),
// and returns the captured result on a valid/ready response port.
module ci_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned N_WIDTH        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    // command port
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [N_WIDTH-1:0] cmd_n,
    input  logic [31:0]        cmd_dataa,
    input  logic [31:0]        cmd_datab,
    // response port
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_result,
    output logic               rsp_timeout,
    output logic [15:0]        rsp_cycles,
    // custom-instruction slave port
    output logic               ci_clk_en,
    output logic               ci_start,
    output logic [N_WIDTH-1:0] ci_n,
    output logic [31:0]        ci_dataa,
    output logic [31:0]        ci_datab,
    output logic               ci_reset,
    input  logic [31:0]        ci_result,
    input  logic               ci_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RECOVER,
        ST_RESP
    } state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    state_t      state;
    state_t      state_next;
    logic [15:0] cycle_cnt;      // start-to-now latency, 1 in the ISSUE cycle
    logic        recover_last;   // high in the second RECOVER cycle
    logic        accept;         // command handshake this cycle
    logic        capture;        // slave done seen in ISSUE/WAIT
    logic        abort;          // recovery finished, emit timeout response
    logic        handshake;      // response handshake this cycle

    // Next-state logic and single-cycle event strobes.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case statement can infer a latch.
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        handshake  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ci_done) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done arriving in the final counted cycle still wins.
                if (ci_done) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else if (cycle_cnt >= TIMEOUT_VAL) begin
                    state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                // ci_done is deliberately not looked at while the slave resets.
                if (recover_last) begin
                    abort      = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    handshake  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus control outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            ci_clk_en <= 1'b0;
            ci_start  <= 1'b0;
            ci_reset  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state     <= state_next;
            cmd_ready <= (state_next == ST_IDLE);
            rsp_valid <= (state_next == ST_RESP);
            ci_clk_en <= (state_next == ST_ISSUE) || (state_next == ST_WAIT) ||
                         (state_next == ST_RECOVER);
            ci_start  <= (state_next == ST_ISSUE);
            ci_reset  <= (state_next == ST_RECOVER);
        end
    end

    // Operand registers, latency counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ci_n         <= '0;
            ci_dataa     <= '0;
            ci_datab     <= '0;
            cycle_cnt    <= '0;
            recover_last <= 1'b0;
            rsp_result   <= '0;
            rsp_timeout  <= 1'b0;
            rsp_cycles   <= '0;
        end else begin
            if (accept) begin
                ci_n      <= cmd_n;
                ci_dataa  <= cmd_dataa;
                ci_datab  <= cmd_datab;
                cycle_cnt <= 16'd1;
            end else if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
                if (cycle_cnt != CNT_MAX) begin
                    cycle_cnt <= cycle_cnt + 16'd1;
                end
            end

            recover_last <= (state == ST_RECOVER) && !recover_last;

            if (capture) begin
                rsp_result  <= ci_result;
                rsp_cycles  <= cycle_cnt;
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_result  <= '0;
                rsp_cycles  <= TIMEOUT_VAL;
                rsp_timeout <= 1'b1;
            end else if (handshake) begin
                rsp_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ci_initiator.sv
// tb_ci_initiator: directed plus randomized bench for ci_initiator. Two
// instances are built (default timeout and TIMEOUT_CYCLES=8); `sel` routes
// stimulus, the slave model and the observed outputs to one of them.
module tb_ci_initiator;

    localparam int NW    = 8;
    localparam int TMO_A = 1024;
    localparam int TMO_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          sel;
    logic          cmd_valid;
    logic [NW-1:0] cmd_n;
    logic [31:0]   cmd_dataa;
    logic [31:0]   cmd_datab;
    logic          rsp_ready;

    logic          slave_done;
    logic [31:0]   slave_res;
    int            slave_lat;    // cycles after start until done, -1 = never
    int            slave_el;
    logic          slave_busy;
    logic          inject_done;  // forced done, used to probe RECOVER

    logic a_cmd_ready, a_rsp_valid, a_rsp_timeout, a_ci_clk_en, a_ci_start, a_ci_reset;
    logic b_cmd_ready, b_rsp_valid, b_rsp_timeout, b_ci_clk_en, b_ci_start, b_ci_reset;
    logic [31:0] a_rsp_result, a_ci_dataa, a_ci_datab;
    logic [31:0] b_rsp_result, b_ci_dataa, b_ci_datab;
    logic [15:0] a_rsp_cycles, b_rsp_cycles;
    logic [NW-1:0] a_ci_n, b_ci_n;

    logic m_cmd_ready, m_rsp_valid, m_rsp_timeout, m_ci_clk_en, m_ci_start, m_ci_reset;
    logic [31:0] m_rsp_result, m_ci_dataa, m_ci_datab;
    logic [15:0] m_rsp_cycles;
    logic [NW-1:0] m_ci_n;

    assign m_cmd_ready   = sel ? b_cmd_ready   : a_cmd_ready;
    assign m_rsp_valid   = sel ? b_rsp_valid   : a_rsp_valid;
    assign m_rsp_timeout = sel ? b_rsp_timeout : a_rsp_timeout;
    assign m_ci_clk_en   = sel ? b_ci_clk_en   : a_ci_clk_en;
    assign m_ci_start    = sel ? b_ci_start    : a_ci_start;
    assign m_ci_reset    = sel ? b_ci_reset    : a_ci_reset;
    assign m_rsp_result  = sel ? b_rsp_result  : a_rsp_result;
    assign m_ci_dataa    = sel ? b_ci_dataa    : a_ci_dataa;
    assign m_ci_datab    = sel ? b_ci_datab    : a_ci_datab;
    assign m_rsp_cycles  = sel ? b_rsp_cycles  : a_rsp_cycles;
    assign m_ci_n        = sel ? b_ci_n        : a_ci_n;

    ci_initiator #(.TIMEOUT_CYCLES(TMO_A), .N_WIDTH(NW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_cmd_ready), .cmd_n(cmd_n),
        .cmd_dataa(cmd_dataa), .cmd_datab(cmd_datab),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(a_rsp_result),
        .rsp_timeout(a_rsp_timeout), .rsp_cycles(a_rsp_cycles),
        .ci_clk_en(a_ci_clk_en), .ci_start(a_ci_start), .ci_n(a_ci_n),
        .ci_dataa(a_ci_dataa), .ci_datab(a_ci_datab), .ci_reset(a_ci_reset),
        .ci_result(slave_res), .ci_done(slave_done & ~sel)
    );

    ci_initiator #(.TIMEOUT_CYCLES(TMO_B), .N_WIDTH(NW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & sel), .cmd_ready(b_cmd_ready), .cmd_n(cmd_n),
        .cmd_dataa(cmd_dataa), .cmd_datab(cmd_datab),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(b_rsp_result),
        .rsp_timeout(b_rsp_timeout), .rsp_cycles(b_rsp_cycles),
        .ci_clk_en(b_ci_clk_en), .ci_start(b_ci_start), .ci_n(b_ci_n),
        .ci_dataa(b_ci_dataa), .ci_datab(b_ci_datab), .ci_reset(b_ci_reset),
        .ci_result(slave_res), .ci_done(slave_done & sel)
    );

    // Slave model: done after slave_lat cycles counted from the start cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slave_busy <= 1'b0;
            slave_el   <= 0;
        end else if (m_ci_start) begin
            slave_busy <= !slave_done;
            slave_el   <= 1;
        end else if (slave_busy && !m_rsp_valid) begin
            slave_busy <= !slave_done;
            slave_el   <= slave_el + 1;
        end else begin
            slave_busy <= 1'b0;
        end
    end

    assign slave_done = inject_done ||
                        (m_ci_start ? (slave_lat == 0)
                                    : (slave_busy && (slave_lat > 0) && (slave_el == slave_lat)));

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected response from the transaction rules: a done k cycles after the
    // start (k=0 same cycle) yields latency k+1 when that fits in the timeout
    // window; otherwise an abort reporting the timeout. Delay is counted in
    // clock edges from the accepting edge to the edge raising rsp_valid:
    // k+1 for a normal response, timeout + 2 (two recovery cycles) for abort.
    function automatic void ref_rsp(input int lat, input int tmo,
                                    output bit to, output int cyc, output int dly);
        if (lat >= 0 && lat + 1 <= tmo) begin
            to  = 1'b0;
            cyc = lat + 1;
            dly = lat + 1;
        end else begin
            to  = 1'b1;
            cyc = tmo;
            dly = tmo + 2;
        end
    endfunction

    task automatic check_reset_vals(input string tag);
        check_b({tag, "_cmd_ready"},   m_cmd_ready,   1'b0);
        check_b({tag, "_rsp_valid"},   m_rsp_valid,   1'b0);
        check_b({tag, "_rsp_timeout"}, m_rsp_timeout, 1'b0);
        check({tag, "_rsp_result"},    m_rsp_result,  32'h0);
        check({tag, "_rsp_cycles"},    32'(m_rsp_cycles), 32'h0);
        check_b({tag, "_ci_clk_en"},   m_ci_clk_en,   1'b0);
        check_b({tag, "_ci_start"},    m_ci_start,    1'b0);
        check_b({tag, "_ci_reset"},    m_ci_reset,    1'b0);
        check({tag, "_ci_n"},          32'(m_ci_n),   32'h0);
        check({tag, "_ci_dataa"},      m_ci_dataa,    32'h0);
        check({tag, "_ci_datab"},      m_ci_datab,    32'h0);
    endtask

    // One complete command/response transaction on the selected instance.
    task automatic run_cmd(input string tag, input int tmo, input logic [NW-1:0] n,
                           input logic [31:0] a, input logic [31:0] b, input int lat,
                           input logic [31:0] res, input int hold, input bit late);
        bit          exp_to;
        int          exp_cyc;
        int          exp_dly;
        int          k;
        int          w;
        int          starts;
        int          resets;
        bit          ops_ok;
        bit          bp_ok;
        logic [31:0] snap_res;
        logic [15:0] snap_cyc;
        logic        snap_to;
        ref_rsp(lat, tmo, exp_to, exp_cyc, exp_dly);
        slave_lat = lat;
        slave_res = res;
        rsp_ready = (hold == 0);
        cmd_n     = n;
        cmd_dataa = a;
        cmd_datab = b;
        cmd_valid = 1'b1;
        w = 0;
        while (!m_cmd_ready && w < 20) begin
            @(posedge clk); @(negedge clk);
            w++;
        end
        check_b({tag, "_cmd_ready"}, m_cmd_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        k = 0; starts = 0; resets = 0; ops_ok = 1'b1;
        while (!m_rsp_valid && k < exp_dly + 8) begin
            if (m_ci_start) starts++;
            if (m_ci_reset) resets++;
            if (!m_ci_clk_en || m_cmd_ready || m_ci_n !== n ||
                m_ci_dataa !== a || m_ci_datab !== b) ops_ok = 1'b0;
            inject_done = late && m_ci_reset;
            @(posedge clk); @(negedge clk);
            k++;
        end
        inject_done = 1'b0;
        check({tag, "_latency"}, k, exp_dly);
        check({tag, "_start_pulses"}, starts, 1);
        check({tag, "_reset_cycles"}, resets, exp_to ? 2 : 0);
        check_b({tag, "_ops_stable"}, ops_ok, 1'b1);
        check_b({tag, "_clk_en_in_resp"}, m_ci_clk_en, 1'b0);
        check({tag, "_rsp_result"}, m_rsp_result, exp_to ? 32'h0 : res);
        check_b({tag, "_rsp_timeout"}, m_rsp_timeout, exp_to);
        check({tag, "_rsp_cycles"}, 32'(m_rsp_cycles), exp_cyc);
        snap_res = m_rsp_result;
        snap_cyc = m_rsp_cycles;
        snap_to  = m_rsp_timeout;
        bp_ok    = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            if (!m_rsp_valid || m_cmd_ready || m_rsp_result !== snap_res ||
                m_rsp_cycles !== snap_cyc || m_rsp_timeout !== snap_to) bp_ok = 1'b0;
        end
        if (hold > 0) check_b({tag, "_backpressure_stable"}, bp_ok, 1'b1);
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check_b({tag, "_rsp_valid_dropped"}, m_rsp_valid, 1'b0);
        check_b({tag, "_cmd_ready_after"}, m_cmd_ready, 1'b1);
        check_b({tag, "_timeout_cleared"}, m_rsp_timeout, 1'b0);
    endtask

    initial begin
        int lat;
        rst_n       = 1'b0;
        sel         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_n       = '0;
        cmd_dataa   = '0;
        cmd_datab   = '0;
        rsp_ready   = 1'b1;
        slave_lat   = -1;
        slave_res   = '0;
        inject_done = 1'b0;

        // Reset values on both instances.
        #12;
        check_reset_vals("rst_a");
        sel = 1'b1;
        #1;
        check_reset_vals("rst_b");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_b("rst_release_ready_low", m_cmd_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        check_b("rst_first_edge_ready", m_cmd_ready, 1'b1);

        // Same-cycle done.
        run_cmd("same_cycle", TMO_A, 8'h01, 32'h42800000, 32'h4DBEBC20, 0, 32'h50BEBC20, 0, 1'b0);

        // Variable latency, three back-to-back commands.
        run_cmd("lat17_0", TMO_A, 8'h02, 32'h3F800000, 32'h40000000, 17, 32'h40400000, 0, 1'b0);
        run_cmd("lat17_1", TMO_A, 8'h03, 32'hC1200000, 32'h41A00000, 17, 32'h41200000, 0, 1'b0);
        run_cmd("lat17_2", TMO_A, 8'h04, 32'h7F7FFFFF, 32'h00800000, 17, 32'h3F000000, 0, 1'b0);

        // Backpressure: rsp_ready low for 20 cycles after rsp_valid.
        run_cmd("backpressure", TMO_A, 8'h05, 32'h12345678, 32'h9ABCDEF0, 3, 32'hCAFEF00D, 20, 1'b0);

        // Randomized commands against the default-timeout instance.
        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("rand_a%0d", i), TMO_A, NW'($urandom), $urandom, $urandom,
                    int'($urandom_range(30, 0)), $urandom, int'($urandom_range(2, 0)), 1'b0);
        end

        // Reset mid-WAIT: command with a slave that never answers.
        slave_lat = -1;
        cmd_n     = 8'h06;
        cmd_dataa = 32'hDEADBEEF;
        cmd_datab = 32'h0BADF00D;
        cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
        end
        check_b("midwait_clk_en", m_ci_clk_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midwait_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_b("midwait_release_ready_low", m_cmd_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        check_b("midwait_ready_back", m_cmd_ready, 1'b1);
        begin
            bit quiet = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (m_rsp_valid || m_ci_start || m_ci_reset) quiet = 1'b0;
                @(posedge clk); @(negedge clk);
            end
            check_b("midwait_no_response", quiet, 1'b1);
        end

        // Short-timeout instance.
        sel = 1'b1;
        #1;
        run_cmd("timeout_late_done", TMO_B, 8'h07, 32'h11111111, 32'h22222222, -1, 32'h55555555, 0, 1'b1);
        run_cmd("tie_done", TMO_B, 8'h08, 32'h33333333, 32'h44444444, TMO_B - 1, 32'h66666666, 0, 1'b0);
        run_cmd("one_past_tie", TMO_B, 8'h09, 32'h77777777, 32'h88888888, TMO_B, 32'h99999999, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            lat = int'($urandom_range(12, 0));
            if (lat >= 10) lat = -1;
            run_cmd($sformatf("rand_b%0d", i), TMO_B, NW'($urandom), $urandom, $urandom,
                    lat, $urandom, int'($urandom_range(3, 0)), 1'(lat < 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
